// File: rtl/l2_port_arbiter_if.sv
// L1 I/D-cache and L2 port bundle for the L2 port arbiter.
// master = arbiter side, slave = caches/L2 side.
interface l2_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              d_read_i;
    logic              d_write_i;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_line_i;
    logic              d_resp_o;
    logic [LINE_W-1:0] d_line_o;
    logic              i_read_i;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp_o;
    logic [LINE_W-1:0] i_line_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_address_o;
    logic [LINE_W-1:0] mem_line_o;
    logic              mem_resp_i;
    logic [LINE_W-1:0] mem_line_i;
    logic              stall;

    modport master (
        input  d_read_i, d_write_i, d_address, d_line_i,
        input  i_read_i, i_address,
        input  mem_resp_i, mem_line_i,
        output d_resp_o, d_line_o, i_resp_o, i_line_o,
        output mem_read_o, mem_write_o, mem_address_o, mem_line_o,
        output stall
    );

    modport slave (
        output d_read_i, d_write_i, d_address, d_line_i,
        output i_read_i, i_address,
        output mem_resp_i, mem_line_i,
        input  d_resp_o, d_line_o, i_resp_o, i_line_o,
        input  mem_read_o, mem_write_o, mem_address_o, mem_line_o,
        input  stall
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Arbitrates the single L2 port between L1 D-cache and I-cache.
// Optional STARVE_GUARD_EN: after STARVE_MAX D grants with I waiting, I wins.
module l2_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    l2_port_arbiter_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        D_RD,
        D_WR,
        I_RD,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              own_d_q, own_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] rline_q, rline_d;
    logic              d_req;
    logic              d_win;

    assign d_req = bus.d_read_i | bus.d_write_i;

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign d_win = d_req && !(bus.i_read_i && cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (d_win) begin
                if (!bus.i_read_i)
                    cnt_d = '0;
                else if (cnt_q != CNT_MAX)
                    cnt_d = cnt_q + CNT_W'(1);
            end else if (bus.i_read_i) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign d_win = d_req;
`endif

    always_comb begin
        state_d = state_q;
        own_d_d = own_d_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        unique case (state_q)
            IDLE: begin
                if (d_win) begin
                    own_d_d = 1'b1;
                    addr_d  = bus.d_address;
                    wline_d = bus.d_line_i;
                    state_d = bus.d_read_i ? D_RD : D_WR;
                end else if (bus.i_read_i) begin
                    own_d_d = 1'b0;
                    addr_d  = bus.i_address;
                    wline_d = bus.d_line_i;
                    state_d = I_RD;
                end
            end
            D_RD, I_RD: begin
                if (bus.mem_resp_i) begin
                    rline_d = bus.mem_line_i;
                    state_d = RESP;
                end
            end
            D_WR: begin
                if (bus.mem_resp_i)
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= IDLE;
            own_d_q <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            own_d_q <= own_d_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // L2 side decodes only registered state, never live inputs
    assign bus.mem_read_o    = (state_q == D_RD) || (state_q == I_RD);
    assign bus.mem_write_o   = (state_q == D_WR);
    assign bus.mem_address_o = addr_q;
    assign bus.mem_line_o    = wline_q;
    assign bus.d_resp_o      = (state_q == RESP) && own_d_q;
    assign bus.i_resp_o      = (state_q == RESP) && !own_d_q;
    assign bus.d_line_o      = rline_q;
    assign bus.i_line_o      = rline_q;
    assign bus.stall         = d_req || bus.i_read_i || (state_q != IDLE);

    a_rd_wr_excl: assert property (
        @(posedge clk) disable iff (reset_n)
        !(bus.d_read_i && bus.d_write_i)
    );
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized bench for l2_port_arbiter against a transaction-level model.
// Build with +define+STARVE_GUARD_EN to exercise the starvation guard.
module tb_l2_port_arbiter;
    localparam int AW   = 32;
    localparam int LW   = 256;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    l2_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    l2_port_arbiter #(
        .ADDR_W(AW),
        .LINE_W(LW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: one outstanding L2 transaction; phase 0 free, 1 at L2, 2 reply
    int          ph = 0;
    bit          m_d = 1'b0;
    bit          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wline = '0;
    logic [LW-1:0] m_rline = '0;
    int          m_cnt = 0;
    int          lat = 0;

    bit d_act = 1'b0;
    bit d_wr = 1'b0;
    bit i_act = 1'b0;
    int mode = 0;

    task automatic check(input string tag,
                         input logic [LW-1:0] got,
                         input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++)
            r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_outputs();
        bit busy;
        busy = bus.d_read_i || bus.d_write_i || bus.i_read_i;
        check("mem_read", bus.mem_read_o, ph == 1 && !m_wr);
        check("mem_write", bus.mem_write_o, ph == 1 && m_wr);
        check("mem_addr", bus.mem_address_o, m_addr);
        check("mem_line", bus.mem_line_o, m_wline);
        check("d_resp", bus.d_resp_o, ph == 2 && m_d);
        check("i_resp", bus.i_resp_o, ph == 2 && !m_d);
        check("d_line", bus.d_line_o, m_rline);
        check("i_line", bus.i_line_o, m_rline);
        check("stall", bus.stall, ph != 0 || busy);
    endtask

    task automatic drive(input int cyc);
        bit exp_d;
        bit exp_i;
        exp_d = (ph == 2) && m_d;
        exp_i = (ph == 2) && !m_d;

        if (mode == 1) begin
            if (exp_d || !d_act) begin
                bus.d_address = $urandom;
                bus.d_line_i  = rand_line();
            end
            d_act = 1'b1;
            d_wr  = 1'b0;
            if (exp_i || !i_act)
                bus.i_address = $urandom;
            i_act = 1'b1;
        end else begin
            if (d_act && (exp_d || $urandom_range(0, 39) == 0))
                d_act = 1'b0;
            if (mode == 0 && !d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1'b1;
                d_wr  = 1'($urandom_range(0, 1));
                bus.d_address = $urandom;
                bus.d_line_i  = rand_line();
            end
            if (i_act && (exp_i || $urandom_range(0, 39) == 0))
                i_act = 1'b0;
            if (mode == 0 && !i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1'b1;
                bus.i_address = $urandom;
            end
        end
        bus.d_read_i  = d_act && !d_wr;
        bus.d_write_i = d_act && d_wr;
        bus.i_read_i  = i_act;

        bus.mem_resp_i = 1'b0;
        if (ph == 1) begin
            if (lat == 0) begin
                bus.mem_resp_i = 1'b1;
                bus.mem_line_i = rand_line();
            end else begin
                lat--;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            bus.mem_resp_i = 1'b1;
            bus.mem_line_i = rand_line();
        end

        reset_n = (cyc < 2) ||
                  (mode == 0 && $urandom_range(0, 149) == 0);
    endtask

    task automatic model_step();
        bit dreq;
        bit dwin;
        if (reset_n) begin
            ph = 0;
            m_d = 1'b0;
            m_wr = 1'b0;
            m_addr = '0;
            m_wline = '0;
            m_rline = '0;
            m_cnt = 0;
            return;
        end
        case (ph)
            0: begin
                dreq = bus.d_read_i || bus.d_write_i;
`ifdef STARVE_GUARD_EN
                dwin = dreq && !(bus.i_read_i && m_cnt == SMAX);
`else
                dwin = dreq;
`endif
                if (dwin) begin
                    m_d = 1'b1;
                    m_wr = !bus.d_read_i;
                    m_addr = bus.d_address;
                    m_wline = bus.d_line_i;
                    m_cnt = bus.i_read_i ? ((m_cnt < SMAX) ? m_cnt + 1 : SMAX) : 0;
                    ph = 1;
                    lat = $urandom_range(0, 3);
                end else if (bus.i_read_i) begin
                    m_d = 1'b0;
                    m_wr = 1'b0;
                    m_addr = bus.i_address;
                    m_wline = bus.d_line_i;
                    m_cnt = 0;
                    ph = 1;
                    lat = $urandom_range(0, 3);
                end
            end
            1: begin
                if (bus.mem_resp_i) begin
                    if (!m_wr)
                        m_rline = bus.mem_line_i;
                    ph = 2;
                end
            end
            default: ph = 0;
        endcase
    endtask

    initial begin
        bus.d_read_i   = 1'b0;
        bus.d_write_i  = 1'b0;
        bus.d_address  = '0;
        bus.d_line_i   = '0;
        bus.i_read_i   = 1'b0;
        bus.i_address  = '0;
        bus.mem_resp_i = 1'b0;
        bus.mem_line_i = '0;
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 3600; cyc++) begin
            @(negedge clk);
            if (cyc < 3000)
                mode = 0;
            else if (cyc < 3300)
                mode = 1;
            else
                mode = 2;
            check_outputs();
            drive(cyc);
            model_step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
